// File: rtl/sk_operand_dispatch.sv
// ============================================================================
// Module   : sk_operand_dispatch
// Brief    : Operand FIFO, issue FSM and result collector for the sequential
//            Kogge-Stone adder. Define SK_DISPATCH_CHECK_EN for a result checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sk_operand_dispatch #(
    parameter int ADDER_WIDTH    = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [ADDER_WIDTH-1:0] IN_A,
    input  logic [ADDER_WIDTH-1:0] IN_B,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [ADDER_WIDTH-1:0] ADD_VAL1,
    output logic [ADDER_WIDTH-1:0] ADD_VAL2,
    output logic                   ADD_VAL1_VALID,
    output logic                   ADD_VAL2_VALID,
    input  logic                   ADDER_READY,
    input  logic [ADDER_WIDTH-1:0] ADDER_OUT_VAL,
    input  logic                   ADDER_OUT_VALID,
    output logic                   ADDER_RST,
    output logic [ADDER_WIDTH-1:0] RES_VAL,
    output logic                   RES_VALID,
    input  logic                   RES_READY,
    output logic                   BUSY,
    output logic                   TIMEOUT_ERR,
    output logic                   MISMATCH_ERR
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_tmr_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [c_ptr_w-1:0] c_ptr_one  = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_one  = 1;
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = 1;
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT    = 3'd2,
        S_RECYCLE = 3'd3,
        S_SETTLE  = 3'd4
    } state_t;

    state_t                   r_state;
    logic [2*ADDER_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]       r_wr_ptr;
    logic [c_ptr_w-1:0]       r_rd_ptr;
    logic [c_cnt_w-1:0]       r_count;
    logic                     r_in_ready;
    logic [ADDER_WIDTH-1:0]   r_add_val1;
    logic [ADDER_WIDTH-1:0]   r_add_val2;
    logic                     r_add_v1;
    logic                     r_add_v2;
    logic [c_tmr_w-1:0]       r_timer;
    logic [ADDER_WIDTH-1:0]   r_res_val;
    logic                     r_res_valid;
    logic                     r_timeout;
    logic                     r_recycle;

    logic                     w_push;
    logic                     w_pop;
    logic [c_cnt_w-1:0]       w_cnt_next;
    logic [2*ADDER_WIDTH-1:0] w_head;

    assign w_push = IN_VALID && r_in_ready;
    assign w_pop  = (r_state == S_ISSUE) && ADDER_READY;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        w_cnt_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_cnt_next = r_count + c_cnt_one;
            2'b01:   w_cnt_next = r_count - c_cnt_one;
            default: w_cnt_next = r_count;
        endcase
    end

    // IN_READY is registered from the next count, so a full FIFO never accepts
    // even when the head is popped in the same cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {IN_A, IN_B};
                r_wr_ptr        <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count    <= w_cnt_next;
            r_in_ready <= (w_cnt_next != c_cnt_full);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_add_val1  <= '0;
            r_add_val2  <= '0;
            r_add_v1    <= 1'b0;
            r_add_v2    <= 1'b0;
            r_timer     <= '0;
            r_res_val   <= '0;
            r_res_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_recycle   <= 1'b0;
        end else begin
            r_recycle <= 1'b0;
            if (r_res_valid && RES_READY) begin
                r_res_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if ((r_count != '0) && !r_res_valid && ADDER_READY) begin
                        r_add_val1 <= w_head[2*ADDER_WIDTH-1:ADDER_WIDTH];
                        r_add_val2 <= w_head[ADDER_WIDTH-1:0];
                        r_add_v1   <= 1'b1;
                        r_add_v2   <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ADDER_READY) begin
                        r_add_v1 <= 1'b0;
                        r_add_v2 <= 1'b0;
                        r_timer  <= '0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (ADDER_OUT_VALID) begin
                        r_res_val   <= ADDER_OUT_VAL;
                        r_res_valid <= 1'b1;
                        r_recycle   <= 1'b1;
                        r_state     <= S_RECYCLE;
                    end else if (r_timer == c_tmr_last) begin
                        r_timeout <= 1'b1;
                        r_recycle <= 1'b1;
                        r_state   <= S_RECYCLE;
                    end else begin
                        r_timer <= r_timer + c_tmr_one;
                    end
                end
                S_RECYCLE: begin
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (ADDER_READY && !ADDER_OUT_VALID) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SK_DISPATCH_CHECK_EN
    logic [ADDER_WIDTH-1:0] r_chk_a;
    logic [ADDER_WIDTH-1:0] r_chk_b;
    logic                   r_mismatch;
    logic [ADDER_WIDTH-1:0] w_expect;

    assign w_expect = r_chk_a + r_chk_b;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_chk_a    <= '0;
            r_chk_b    <= '0;
            r_mismatch <= 1'b0;
        end else begin
            if (w_pop) begin
                r_chk_a <= r_add_val1;
                r_chk_b <= r_add_val2;
            end
            if ((r_state == S_WAIT) && ADDER_OUT_VALID && (ADDER_OUT_VAL != w_expect)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign MISMATCH_ERR = r_mismatch;
`else
    assign MISMATCH_ERR = 1'b0;
`endif

    assign IN_READY       = r_in_ready;
    assign ADD_VAL1       = r_add_val1;
    assign ADD_VAL2       = r_add_val2;
    assign ADD_VAL1_VALID = r_add_v1;
    assign ADD_VAL2_VALID = r_add_v2;
    assign ADDER_RST      = RST | r_recycle;
    assign RES_VAL        = r_res_val;
    assign RES_VALID      = r_res_valid;
    assign BUSY           = (r_state != S_IDLE) || (r_count != '0);
    assign TIMEOUT_ERR    = r_timeout;

endmodule

`default_nettype wire
